// File: rtl/srio_pkg.sv
// rtl/srio_pkg.sv - shared SRIO logical-layer constants, header offsets and FSM states
package srio_pkg;

    localparam logic [3:0]  FTYPE_DOORB = 4'hA;
    localparam logic [3:0]  FTYPE_NWR   = 4'h5;
    localparam logic [3:0]  TTYPE_NWR   = 4'h4;

    localparam logic [15:0] DB_SELFCHK  = 16'h0101;
    localparam logic [15:0] DB_READY    = 16'h0100;
    localparam logic [15:0] DB_BUSY     = 16'h01FF;
    localparam logic [7:0]  DB_INTEG_HI = 8'h02;

    localparam int TID_LSB   = 56;
    localparam int FTYPE_LSB = 52;
    localparam int TTYPE_LSB = 48;
    localparam int PRIO_LSB  = 45;
    localparam int SIZE_LSB  = 36;
    localparam int INFO_LSB  = 16;
    localparam int ADDR_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DB_RESP,
        ST_NWR_DATA,
        ST_DROP
    } state_t;

endpackage

// File: rtl/srio_hdr_decode.sv
// rtl/srio_hdr_decode.sv - combinational split of a 64-bit HELLO header into its fields
module srio_hdr_decode
    import srio_pkg::*;
(
    input  logic [63:0] hdr,
    output logic [7:0]  tid,
    output logic [3:0]  ftype,
    output logic [3:0]  ttype,
    output logic [1:0]  prio,
    output logic [7:0]  size,
    output logic [33:0] addr,
    output logic [15:0] info
);

    logic unused_rsvd;

    assign tid   = hdr[TID_LSB   +: 8];
    assign ftype = hdr[FTYPE_LSB +: 4];
    assign ttype = hdr[TTYPE_LSB +: 4];
    assign prio  = hdr[PRIO_LSB  +: 2];
    assign size  = hdr[SIZE_LSB  +: 8];
    assign addr  = hdr[ADDR_LSB  +: 34];
    assign info  = hdr[INFO_LSB  +: 16];

    // Reserved header bits carry no meaning for this endpoint.
    assign unused_rsvd = ^{hdr[47], hdr[44], hdr[35:34]};

endmodule

// File: rtl/db_nwr_target.sv
// rtl/db_nwr_target.sv - SRIO target endpoint: doorbell responder and NWRITE unpacker
module db_nwr_target
    import srio_pkg::*;
#(
    parameter logic [7:0] TARGET_ID = 8'hF0,
    parameter int         MAX_BEATS = 32
) (
    input  logic        log_clk,
    input  logic        log_rst,
    input  logic        treq_tvalid_in,
    output logic        treq_tready_o,
    input  logic        treq_tlast_in,
    input  logic [63:0] treq_tdata_in,
    input  logic [7:0]  treq_tkeep_in,
    input  logic [31:0] treq_tuser_in,
    output logic        tresp_tvalid_o,
    input  logic        tresp_tready_in,
    output logic        tresp_tlast_o,
    output logic [63:0] tresp_tdata_o,
    output logic [7:0]  tresp_tkeep_o,
    output logic [31:0] tresp_tuser_o,
    input  logic        user_busy_in,
    output logic        wr_valid_o,
    output logic [33:0] wr_addr_o,
    output logic [63:0] wr_data_o,
    output logic [7:0]  wr_keep_o,
    output logic        wr_last_o,
    output logic        nwr_done_o,
    output logic        len_err_o,
    output logic        integ_db_o,
    output logic [15:0] integ_info_o
);

    localparam int                 CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_BEATS);

    logic [7:0]       hdr_tid;
    logic [3:0]       hdr_ftype;
    logic [3:0]       hdr_ttype;
    logic [1:0]       hdr_prio;
    logic [7:0]       hdr_size;
    logic [33:0]      hdr_addr;
    logic [15:0]      hdr_info;

    state_t           state;
    logic [33:0]      base_addr;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] exp_beats;
    logic             hs;
    logic             is_integ;
    logic [15:0]      rinfo;
    logic             unused_bits;

    srio_hdr_decode u_hdr_decode (
        .hdr   (treq_tdata_in),
        .tid   (hdr_tid),
        .ftype (hdr_ftype),
        .ttype (hdr_ttype),
        .prio  (hdr_prio),
        .size  (hdr_size),
        .addr  (hdr_addr),
        .info  (hdr_info)
    );

    assign hs          = treq_tvalid_in && treq_tready_o;
    assign is_integ    = (hdr_info[15:8] == DB_INTEG_HI);
    assign rinfo       = (hdr_info == DB_SELFCHK && user_busy_in) ? DB_BUSY : DB_READY;
    assign unused_bits = ^{treq_tuser_in[31:24], treq_tuser_in[15:0], hdr_size[2:0]};

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            state          <= ST_IDLE;
            treq_tready_o  <= 1'b0;
            tresp_tvalid_o <= 1'b0;
            tresp_tlast_o  <= 1'b0;
            tresp_tdata_o  <= '0;
            tresp_tkeep_o  <= '0;
            tresp_tuser_o  <= '0;
            wr_valid_o     <= 1'b0;
            wr_addr_o      <= '0;
            wr_data_o      <= '0;
            wr_keep_o      <= '0;
            wr_last_o      <= 1'b0;
            nwr_done_o     <= 1'b0;
            len_err_o      <= 1'b0;
            integ_db_o     <= 1'b0;
            integ_info_o   <= '0;
            base_addr      <= '0;
            beat_cnt       <= '0;
            exp_beats      <= '0;
        end else begin
            wr_valid_o <= 1'b0;
            wr_last_o  <= 1'b0;
            nwr_done_o <= 1'b0;
            len_err_o  <= 1'b0;
            integ_db_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    treq_tready_o <= 1'b1;
                    if (hs) begin
                        if (hdr_ftype == FTYPE_DOORB) begin
                            if (hdr_info == DB_SELFCHK || is_integ) begin
                                treq_tready_o  <= 1'b0;
                                tresp_tvalid_o <= 1'b1;
                                tresp_tlast_o  <= 1'b1;
                                tresp_tkeep_o  <= 8'hFF;
                                tresp_tdata_o  <= {hdr_tid, FTYPE_DOORB, 4'h0, 1'b0,
                                                   hdr_prio + 2'b01, 1'b0, 12'h0, rinfo, 16'h0};
                                tresp_tuser_o  <= {8'h0, TARGET_ID, 8'h0, treq_tuser_in[23:16]};
                                if (is_integ) begin
                                    integ_db_o   <= 1'b1;
                                    integ_info_o <= hdr_info;
                                end
                                state <= ST_DB_RESP;
                            end else if (!treq_tlast_in) begin
                                state <= ST_DROP;
                            end
                        end else if (hdr_ftype == FTYPE_NWR && hdr_ttype == TTYPE_NWR) begin
                            if (treq_tlast_in) begin
                                len_err_o <= 1'b1;
                            end else begin
                                base_addr <= hdr_addr;
                                beat_cnt  <= '0;
                                exp_beats <= CNT_W'(hdr_size[7:3]) + CNT_W'(1);
                                state     <= ST_NWR_DATA;
                            end
                        end else if (!treq_tlast_in) begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_DB_RESP: begin
                    treq_tready_o <= 1'b0;
                    if (tresp_tready_in) begin
                        tresp_tvalid_o <= 1'b0;
                        tresp_tlast_o  <= 1'b0;
                        tresp_tdata_o  <= '0;
                        tresp_tkeep_o  <= '0;
                        tresp_tuser_o  <= '0;
                        treq_tready_o  <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                ST_NWR_DATA: begin
                    treq_tready_o <= 1'b1;
                    if (hs) begin
                        // Beats past MAX_BEATS are never written; the packet is already bad.
                        if (beat_cnt == MAX_CNT) begin
                            len_err_o <= 1'b1;
                            state     <= treq_tlast_in ? ST_IDLE : ST_DROP;
                        end else begin
                            wr_valid_o <= 1'b1;
                            wr_addr_o  <= base_addr + (34'(beat_cnt) << 3);
                            wr_data_o  <= treq_tdata_in;
                            wr_keep_o  <= treq_tkeep_in;
                            wr_last_o  <= treq_tlast_in;
                            beat_cnt   <= beat_cnt + CNT_W'(1);
                            if (treq_tlast_in) begin
                                if (beat_cnt + CNT_W'(1) == exp_beats)
                                    nwr_done_o <= 1'b1;
                                else
                                    len_err_o <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    treq_tready_o <= 1'b1;
                    if (hs && treq_tlast_in)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_db_nwr_target.sv
// tb/tb_db_nwr_target.sv - directed table-driven bench for db_nwr_target
module tb_db_nwr_target;

    logic        log_clk = 1'b0;
    logic        log_rst;
    logic        treq_tvalid_in;
    logic        treq_tready_o;
    logic        treq_tlast_in;
    logic [63:0] treq_tdata_in;
    logic [7:0]  treq_tkeep_in;
    logic [31:0] treq_tuser_in;
    logic        tresp_tvalid_o;
    logic        tresp_tready_in;
    logic        tresp_tlast_o;
    logic [63:0] tresp_tdata_o;
    logic [7:0]  tresp_tkeep_o;
    logic [31:0] tresp_tuser_o;
    logic        user_busy_in;
    logic        wr_valid_o;
    logic [33:0] wr_addr_o;
    logic [63:0] wr_data_o;
    logic [7:0]  wr_keep_o;
    logic        wr_last_o;
    logic        nwr_done_o;
    logic        len_err_o;
    logic        integ_db_o;
    logic [15:0] integ_info_o;

    db_nwr_target dut (
        .log_clk         (log_clk),
        .log_rst         (log_rst),
        .treq_tvalid_in  (treq_tvalid_in),
        .treq_tready_o   (treq_tready_o),
        .treq_tlast_in   (treq_tlast_in),
        .treq_tdata_in   (treq_tdata_in),
        .treq_tkeep_in   (treq_tkeep_in),
        .treq_tuser_in   (treq_tuser_in),
        .tresp_tvalid_o  (tresp_tvalid_o),
        .tresp_tready_in (tresp_tready_in),
        .tresp_tlast_o   (tresp_tlast_o),
        .tresp_tdata_o   (tresp_tdata_o),
        .tresp_tkeep_o   (tresp_tkeep_o),
        .tresp_tuser_o   (tresp_tuser_o),
        .user_busy_in    (user_busy_in),
        .wr_valid_o      (wr_valid_o),
        .wr_addr_o       (wr_addr_o),
        .wr_data_o       (wr_data_o),
        .wr_keep_o       (wr_keep_o),
        .wr_last_o       (wr_last_o),
        .nwr_done_o      (nwr_done_o),
        .len_err_o       (len_err_o),
        .integ_db_o      (integ_db_o),
        .integ_info_o    (integ_info_o)
    );

    always #5 log_clk = ~log_clk;

    typedef struct {
        logic [63:0] hdr;
        logic [7:0]  src;
        logic        busy;
        logic        exp_resp;
        logic [63:0] exp_data;
        logic        exp_integ;
    } db_vec_t;

    db_vec_t     dbv [4];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_info = 16'h0;
    logic [63:0] d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge log_clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] data, input logic last, input logic [7:0] keep,
                             input logic [31:0] user);
        int n = 0;
        treq_tvalid_in = 1'b1;
        treq_tdata_in  = data;
        treq_tlast_in  = last;
        treq_tkeep_in  = keep;
        treq_tuser_in  = user;
        while (!treq_tready_o && n < 20) begin
            tick();
            n++;
        end
        if (!treq_tready_o) begin
            checks++;
            errors++;
            $display("FAIL treq_ready_timeout: got 0 expected 1");
        end
        tick();
    endtask

    function automatic logic [63:0] make_nwr(input logic [7:0] tid, input logic [7:0] size,
                                             input logic [33:0] addr);
        logic [63:0] h;
        h        = '0;
        h[63:56] = tid;
        h[55:52] = 4'h5;
        h[51:48] = 4'h4;
        h[43:36] = size;
        h[33:0]  = addr;
        return h;
    endfunction

    task automatic run_db(input int i);
        user_busy_in = dbv[i].busy;
        send_beat(dbv[i].hdr, 1'b1, 8'hFF, {8'h0, dbv[i].src, 8'h0, 8'hF0});
        treq_tvalid_in = 1'b0;
        check($sformatf("db%0d_resp_valid", i), tresp_tvalid_o, dbv[i].exp_resp);
        if (dbv[i].exp_resp) begin
            check($sformatf("db%0d_resp_data", i), tresp_tdata_o, dbv[i].exp_data);
            check($sformatf("db%0d_resp_user", i), tresp_tuser_o, {8'h0, 8'hF0, 8'h0, dbv[i].src});
            check($sformatf("db%0d_resp_last", i), tresp_tlast_o, 1'b1);
            check($sformatf("db%0d_resp_keep", i), tresp_tkeep_o, 8'hFF);
            check($sformatf("db%0d_treq_ready", i), treq_tready_o, 1'b0);
        end
        check($sformatf("db%0d_integ_db", i), integ_db_o, dbv[i].exp_integ);
        if (dbv[i].exp_integ) exp_info = dbv[i].hdr[31:16];
        check($sformatf("db%0d_integ_info", i), integ_info_o, exp_info);
        tick();
        check($sformatf("db%0d_resp_done", i), tresp_tvalid_o, 1'b0);
        check($sformatf("db%0d_idle_ready", i), treq_tready_o, 1'b1);
    endtask

    initial begin
        dbv[0] = '{hdr: 64'h07A0_2000_0101_0000, src: 8'h01, busy: 1'b0, exp_resp: 1'b1,
                   exp_data: 64'h07A0_4000_0100_0000, exp_integ: 1'b0};
        dbv[1] = '{hdr: 64'h3CA0_6000_0101_0000, src: 8'h5A, busy: 1'b1, exp_resp: 1'b1,
                   exp_data: 64'h3CA0_0000_01FF_0000, exp_integ: 1'b0};
        dbv[2] = '{hdr: 64'h11A0_0000_0201_0000, src: 8'h22, busy: 1'b1, exp_resp: 1'b1,
                   exp_data: 64'h11A0_2000_0100_0000, exp_integ: 1'b1};
        dbv[3] = '{hdr: 64'h22A0_0000_1234_0000, src: 8'h33, busy: 1'b0, exp_resp: 1'b0,
                   exp_data: 64'h0, exp_integ: 1'b0};

        log_rst = 1'b1;
        treq_tvalid_in = 1'b0;
        treq_tlast_in = 1'b0;
        treq_tdata_in = '0;
        treq_tkeep_in = '0;
        treq_tuser_in = '0;
        tresp_tready_in = 1'b1;
        user_busy_in = 1'b0;
        repeat (3) tick();
        check("rst_treq_ready", treq_tready_o, 1'b0);
        check("rst_tresp_valid", tresp_tvalid_o, 1'b0);
        check("rst_wr_valid", wr_valid_o, 1'b0);
        check("rst_integ_info", integ_info_o, 16'h0);
        log_rst = 1'b0;
        tick();
        check("post_rst_ready", treq_tready_o, 1'b1);

        for (int i = 0; i < 4; i++) run_db(i);

        // Busy reply held under response backpressure.
        user_busy_in = 1'b1;
        tresp_tready_in = 1'b0;
        send_beat(64'h07A0_2000_0101_0000, 1'b1, 8'hFF, 32'h0001_00F0);
        treq_tvalid_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", tresp_tvalid_o, 1'b1);
            check("bp_data", tresp_tdata_o, 64'h07A0_4000_01FF_0000);
            check("bp_treq_ready", treq_tready_o, 1'b0);
            tick();
        end
        tresp_tready_in = 1'b1;
        tick();
        check("bp_release", tresp_tvalid_o, 1'b0);
        user_busy_in = 1'b0;

        // Full 32-beat NWRITE.
        send_beat(make_nwr(8'h01, 8'hFF, 34'h10_0000), 1'b0, 8'hFF, 32'h0001_00F0);
        check("nwr_hdr_nowrite", wr_valid_o, 1'b0);
        for (int b = 0; b < 32; b++) begin
            d = 64'hD000_0000_0000_0000 + 64'(b * 7);
            send_beat(d, b == 31, 8'hFF, 32'h0001_00F0);
            check("nwr_valid", wr_valid_o, 1'b1);
            check("nwr_addr", wr_addr_o, 34'h10_0000 + 34'(b * 8));
            check("nwr_data", wr_data_o, d);
            check("nwr_last", wr_last_o, b == 31);
            check("nwr_done", nwr_done_o, b == 31);
            check("nwr_len_err", len_err_o, 1'b0);
        end
        treq_tvalid_in = 1'b0;
        tick();
        check("nwr_done_pulse", nwr_done_o, 1'b0);
        check("nwr_idle_nowrite", wr_valid_o, 1'b0);

        // Short NWRITE with address wrap and a 3-beat / 2-expected mismatch.
        send_beat(make_nwr(8'h02, 8'h0F, 34'h3_FFFF_FFF8), 1'b0, 8'hFF, 32'h0001_00F0);
        send_beat(64'h1111, 1'b0, 8'hFF, 32'h0001_00F0);
        check("short_addr0", wr_addr_o, 34'h3_FFFF_FFF8);
        send_beat(64'h2222, 1'b0, 8'h0F, 32'h0001_00F0);
        check("short_addr_wrap", wr_addr_o, 34'h0);
        check("short_keep", wr_keep_o, 8'h0F);
        send_beat(64'h3333, 1'b1, 8'hFF, 32'h0001_00F0);
        check("short_write3", wr_valid_o, 1'b1);
        check("short_addr2", wr_addr_o, 34'h8);
        check("short_len_err", len_err_o, 1'b1);
        check("short_no_done", nwr_done_o, 1'b0);
        send_beat(make_nwr(8'h03, 8'h07, 34'h40), 1'b1, 8'hFF, 32'h0001_00F0);
        treq_tvalid_in = 1'b0;
        check("hdr_only_len_err", len_err_o, 1'b1);
        check("hdr_only_nowrite", wr_valid_o, 1'b0);
        check("hdr_only_ready", treq_tready_o, 1'b1);

        // 33 beats without tlast: overlength error, then drop.
        send_beat(make_nwr(8'h04, 8'hFF, 34'h2000), 1'b0, 8'hFF, 32'h0001_00F0);
        for (int b = 0; b < 32; b++) send_beat(64'(b), 1'b0, 8'hFF, 32'h0001_00F0);
        check("ovl_beat32_write", wr_valid_o, 1'b1);
        check("ovl_beat32_nolast", wr_last_o, 1'b0);
        send_beat(64'hBAD, 1'b0, 8'hFF, 32'h0001_00F0);
        check("ovl_nowrite", wr_valid_o, 1'b0);
        check("ovl_len_err", len_err_o, 1'b1);
        send_beat(64'hBAD2, 1'b1, 8'hFF, 32'h0001_00F0);
        check("ovl_drop_nowrite", wr_valid_o, 1'b0);
        check("ovl_drop_no_err", len_err_o, 1'b0);
        treq_tvalid_in = 1'b0;

        // Unknown ftype, 4 beats: silently consumed.
        send_beat(64'h0520_0000_0000_0000, 1'b0, 8'hFF, 32'h0001_00F0);
        for (int b = 0; b < 3; b++) begin
            send_beat(64'hCAFE + 64'(b), b == 2, 8'hFF, 32'h0001_00F0);
            check("drop_nowrite", wr_valid_o, 1'b0);
            check("drop_noresp", tresp_tvalid_o, 1'b0);
        end
        treq_tvalid_in = 1'b0;
        check("drop_ready", treq_tready_o, 1'b1);

        // Reset in the middle of an NWRITE.
        send_beat(make_nwr(8'h05, 8'hFF, 34'h8000), 1'b0, 8'hFF, 32'h0001_00F0);
        for (int b = 0; b < 10; b++) send_beat(64'(b), 1'b0, 8'hFF, 32'h0001_00F0);
        log_rst = 1'b1;
        tick();
        check("mid_rst_wr_valid", wr_valid_o, 1'b0);
        check("mid_rst_wr_addr", wr_addr_o, 34'h0);
        check("mid_rst_ready", treq_tready_o, 1'b0);
        check("mid_rst_integ_info", integ_info_o, 16'h0);
        check("mid_rst_tresp", tresp_tvalid_o, 1'b0);
        exp_info = 16'h0;
        log_rst = 1'b0;
        treq_tvalid_in = 1'b0;
        tick();
        run_db(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
